// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if: hazard requests into, and per-stage stall/flush/redirect out of, the hold controller
interface pipe_hold_ctrl_if #(parameter int AW = 32);
    logic          jump_req_i;
    logic [AW-1:0] jump_addr_i;
    logic          load_use_i;
    logic          div_busy_i;
    logic          mem_busy_i;
    logic          irq_i;
    logic [AW-1:0] irq_vec_i;
    logic          pc_stall_o;
    logic [3:0]    stall_o;
    logic [3:0]    hold_en_o;
    logic          jump_flag_o;
    logic [AW-1:0] jump_addr_o;
    logic          irq_ack_o;
    modport master (
        input  jump_req_i, jump_addr_i, load_use_i, div_busy_i, mem_busy_i, irq_i, irq_vec_i,
        output pc_stall_o, stall_o, hold_en_o, jump_flag_o, jump_addr_o, irq_ack_o
    );
    modport slave (
        output jump_req_i, jump_addr_i, load_use_i, div_busy_i, mem_busy_i, irq_i, irq_vec_i,
        input  pc_stall_o, stall_o, hold_en_o, jump_flag_o, jump_addr_o, irq_ack_o
    );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: merges ID/EX/bus hazards and interrupt entry into per-stage stall/flush and one PC redirect
module pipe_hold_ctrl #(
    parameter int AW        = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hold_ctrl_if.master  bus
);
    typedef enum logic [1:0] {RUN, PEND, DRAIN, IRQJ} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [3:0]    drain_cnt_q, drain_cnt_d;
    logic          pc_stall_c, jump_flag_c, irq_ack_c, busy;
    logic [3:0]    stall_c, hold_c;
    logic [AW-1:0] jump_addr_c;
    assign busy = bus.mem_busy_i | bus.div_busy_i;
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        drain_cnt_d = drain_cnt_q;
        pc_stall_c  = busy;
        stall_c     = bus.mem_busy_i ? 4'b1111 : bus.div_busy_i ? 4'b0011 : 4'b0000;
        hold_c      = !bus.mem_busy_i && bus.div_busy_i ? 4'b0100 : 4'b0000;
        jump_flag_c = 1'b0;
        jump_addr_c = '0;
        irq_ack_c   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (busy) begin
                    if (bus.jump_req_i) begin
                        pend_addr_d = bus.jump_addr_i;
                        state_d     = PEND;
                    end
                end else if (bus.jump_req_i) begin
                    jump_flag_c = 1'b1;
                    jump_addr_c = bus.jump_addr_i;
                    hold_c      = 4'b0011;
                end else begin
                    pc_stall_c = bus.load_use_i;
                    stall_c    = {3'b000, bus.load_use_i};
                    hold_c     = {2'b00, bus.load_use_i, 1'b0};
                    if (bus.irq_i) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 4'(DRAIN_CYC);
                    end
                end
            end
            PEND: begin
                if (busy) begin
                    if (bus.jump_req_i) pend_addr_d = bus.jump_addr_i;
                end else begin
                    jump_flag_c = 1'b1;
                    jump_addr_c = pend_addr_q;
                    hold_c      = 4'b0011;
                    state_d     = RUN;
                end
            end
            DRAIN: begin
                if (bus.jump_req_i && !busy) begin
                    jump_flag_c = 1'b1;
                    jump_addr_c = bus.jump_addr_i;
                    hold_c      = 4'b0011;
                    drain_cnt_d = 4'(DRAIN_CYC);
                end else begin
                    // IF/ID bubble must not collide with a busy stall on the same register
                    pc_stall_c = 1'b1;
                    hold_c     = (hold_c | 4'b0001) & ~stall_c;
                    if (bus.jump_req_i) begin
                        pend_addr_d = bus.jump_addr_i;
                        state_d     = PEND;
                    end else if (!bus.mem_busy_i) begin
                        drain_cnt_d = drain_cnt_q - 4'd1;
                        if (drain_cnt_q == 4'd1) state_d = IRQJ;
                    end
                end
            end
            IRQJ: begin
                if (!bus.mem_busy_i) begin
                    pc_stall_c  = 1'b0;
                    stall_c     = 4'b0000;
                    hold_c      = 4'b0011;
                    jump_flag_c = 1'b1;
                    jump_addr_c = bus.irq_vec_i;
                    irq_ack_c   = 1'b1;
                    state_d     = RUN;
                end
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            pend_addr_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end
    assign bus.pc_stall_o  = rst & pc_stall_c;
    assign bus.stall_o     = rst ? stall_c : 4'b0000;
    assign bus.hold_en_o   = rst ? hold_c : 4'b0000;
    assign bus.jump_flag_o = rst & jump_flag_c;
    assign bus.jump_addr_o = rst ? jump_addr_c : '0;
    assign bus.irq_ack_o   = rst & irq_ack_c;
endmodule
